// File: rtl/cla_add_arbiter.sv
// cla_add_arbiter: round-robin time-sharing of one 32-bit CLA between NUM_REQ add/sub requesters

// b32_cla: 32-bit two-level carry-lookahead adder with signed overflow
module b32_cla (
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        c_in,
    output logic [31:0] z,
    output logic        overflow
);
    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;
    logic [7:0]  gg;
    logic [7:0]  gp;
    // 4-bit lookahead groups chained by group generate/propagate
    always_comb begin
        g = x & y;
        p = x ^ y;
        c = '0;
        c[0] = c_in;
        gg = '0;
        gp = '0;
        for (int k = 0; k < 8; k++) begin
            gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (&p[4*k+3 -: 2] & g[4*k+1]) | (&p[4*k+3 -: 3] & g[4*k]);
            gp[k] = &p[4*k +: 4];
            c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (&p[4*k +: 2] & c[4*k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (&p[4*k+1 +: 2] & g[4*k]) | (&p[4*k +: 3] & c[4*k]);
            c[4*k+4] = gg[k] | (gp[k] & c[4*k]);
        end
        z = p ^ c[31:0];
        overflow = c[32] ^ c[31];
    end
endmodule

module cla_add_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    input  logic [NUM_REQ-1:0]    req_sub,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_W-1:0]       resp_id,
    output logic [31:0]           resp_sum,
    output logic                  resp_overflow
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] rr_last_q, rr_last_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [ID_W-1:0] resp_id_q, resp_id_d;
    logic [31:0]     op_a_q, op_a_d;
    logic [31:0]     op_b_q, op_b_d;
    logic [31:0]     resp_sum_q, resp_sum_d;
    logic            sub_q, sub_d;
    logic            resp_valid_q, resp_valid_d;
    logic            resp_overflow_q, resp_overflow_d;
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] idx;
    logic [31:0]     sel_a;
    logic [31:0]     sel_b;
    logic            sel_sub;
    logic            found;
    logic            grant;
    logic [31:0]     add_y;
    logic [31:0]     add_z;
    logic            add_ovf;

    // round-robin search from rr_last+1 and operand mux for the winner
    always_comb begin
        found = 1'b0;
        win = '0;
        idx = '0;
        sel_a = '0;
        sel_b = '0;
        sel_sub = 1'b0;
        for (int o = 1; o <= NUM_REQ; o++) begin
            idx = ID_W'((int'(rr_last_q) + o) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win = idx;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == ID_W'(i)) begin
                sel_a = req_a[32*i +: 32];
                sel_b = req_b[32*i +: 32];
                sel_sub = req_sub[i];
            end
        end
    end

    assign grant     = !rst && found && (state_q == IDLE || (state_q == RESP && resp_ready));
    assign req_ready = grant ? (NUM_REQ'(1) << win) : '0;
    assign add_y     = sub_q ? ~op_b_q : op_b_q;

    b32_cla u_cla (
        .x        (op_a_q),
        .y        (add_y),
        .c_in     (sub_q),
        .z        (add_z),
        .overflow (add_ovf)
    );

    // next-state: grant latches operands, EXEC captures the adder, RESP waits for the consumer
    always_comb begin
        state_d = state_q;
        rr_last_d = rr_last_q;
        id_d = id_q;
        op_a_d = op_a_q;
        op_b_d = op_b_q;
        sub_d = sub_q;
        resp_valid_d = resp_valid_q;
        resp_id_d = resp_id_q;
        resp_sum_d = resp_sum_q;
        resp_overflow_d = resp_overflow_q;
        if (grant) begin
            op_a_d = sel_a;
            op_b_d = sel_b;
            sub_d = sel_sub;
            id_d = win;
            rr_last_d = win;
            state_d = EXEC;
        end
        if (state_q == EXEC) begin
            resp_sum_d = add_z;
            resp_overflow_d = add_ovf;
            resp_id_d = id_q;
            resp_valid_d = 1'b1;
            state_d = RESP;
        end
        if (state_q == RESP && resp_ready) begin
            resp_valid_d = 1'b0;
            state_d = grant ? EXEC : IDLE;
        end
    end

    // state registers; reset drops any in-flight operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_last_q <= ID_W'(NUM_REQ - 1);
            id_q <= '0;
            op_a_q <= '0;
            op_b_q <= '0;
            sub_q <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_id_q <= '0;
            resp_sum_q <= '0;
            resp_overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_last_q <= rr_last_d;
            id_q <= id_d;
            op_a_q <= op_a_d;
            op_b_q <= op_b_d;
            sub_q <= sub_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q <= resp_id_d;
            resp_sum_q <= resp_sum_d;
            resp_overflow_q <= resp_overflow_d;
        end
    end

    assign resp_valid    = resp_valid_q;
    assign resp_id       = resp_id_q;
    assign resp_sum      = resp_sum_q;
    assign resp_overflow = resp_overflow_q;
endmodule

// File: tb/tb_cla_add_arbiter.sv
// tb_cla_add_arbiter: table vectors plus scoreboard-checked sequences for cla_add_arbiter
module tb_cla_add_arbiter;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [32*N-1:0] req_a;
    logic [32*N-1:0] req_b;
    logic [N-1:0]   req_sub;
    logic           resp_valid;
    logic           resp_ready;
    logic [1:0]     resp_id;
    logic [31:0]    resp_sum;
    logic           resp_overflow;

    always #5 clk = ~clk;

    cla_add_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_sub       (req_sub),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_id       (resp_id),
        .resp_sum      (resp_sum),
        .resp_overflow (resp_overflow)
    );

    typedef struct {
        logic [1:0]  id;
        logic [31:0] sum;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] sum;
        logic        ovf;
    } vec_t;

    exp_t       sb[$];
    int         grant_log[$];
    int         resp_log[$];
    int         resp_tick[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         n_tick = 0;
    logic [N-1:0] last_ready;
    vec_t       vt[8];
    int         exp_order[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] id, input logic [31:0] a, input logic [31:0] b, input logic sub);
        exp_t e;
        e.id = id;
        e.sum = sub ? a - b : a + b;
        e.ovf = sub ? (a[31] != b[31] && e.sum[31] != a[31]) : (a[31] == b[31] && e.sum[31] != a[31]);
        return e;
    endfunction

    // observes the cycle's final inputs before the rising edge: handshakes feed/drain the scoreboard
    task automatic mon();
        exp_t e;
        last_ready = req_ready;
        if (rst) begin
            chk("rst_ready", 64'(req_ready), 64'd0);
            sb.delete();
        end else begin
            chk("ready_legal", 64'($onehot0(req_ready) && ((req_ready & ~req_valid) == '0)), 64'd1);
            for (int i = 0; i < N; i++) begin
                if (req_ready[i] && req_valid[i]) begin
                    sb.push_back(model(2'(i), req_a[32*i +: 32], req_b[32*i +: 32], req_sub[i]));
                    grant_log.push_back(i);
                end
            end
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected_resp: got id %0d sum %0h, expected no response", resp_id, resp_sum);
                end else begin
                    e = sb.pop_front();
                    chk("sb_id", 64'(resp_id), 64'(e.id));
                    chk("sb_sum", 64'(resp_sum), 64'(e.sum));
                    chk("sb_ovf", 64'(resp_overflow), 64'(e.ovf));
                end
                resp_log.push_back(int'(resp_id));
                resp_tick.push_back(n_tick);
            end
        end
        n_tick++;
    endtask

    task automatic tick();
        #1;
        mon();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
        req_valid[i] = 1'b1;
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_sub[i] = s;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        vt[0] = '{2'd0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b1};
        vt[1] = '{2'd2, 32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0};
        vt[2] = '{2'd1, 32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1};
        vt[3] = '{2'd3, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b0};
        vt[4] = '{2'd0, 32'h00000000, 32'h80000000, 1'b1, 32'h80000000, 1'b1};
        vt[5] = '{2'd1, 32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0};
        vt[6] = '{2'd2, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
        vt[7] = '{2'd3, 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h80000000, 1'b1};
        exp_order = '{0, 1, 2, 3, 0, 1};

        rst = 1'b1;
        req_valid = '1;
        req_a = '0;
        req_b = '0;
        req_sub = '0;
        resp_ready = 1'b0;
        tick();
        tick();
        req_valid = '0;
        chk("reset_resp_valid", 64'(resp_valid), 64'd0);
        chk("reset_resp_id", 64'(resp_id), 64'd0);
        chk("reset_resp_sum", 64'(resp_sum), 64'd0);
        chk("reset_resp_ovf", 64'(resp_overflow), 64'd0);
        rst = 1'b0;

        repeat (10) begin
            tick();
            chk("idle_ready", 64'(last_ready), 64'd0);
            chk("idle_resp_valid", 64'(resp_valid), 64'd0);
        end

        for (int v = 0; v < 8; v++) begin
            resp_ready = 1'b1;
            set_req(int'(vt[v].id), vt[v].a, vt[v].b, vt[v].sub);
            tick();
            chk("vec_grant", 64'(last_ready), 64'(N'(1) << vt[v].id));
            req_valid[vt[v].id] = 1'b0;
            chk("vec_lat_t1", 64'(resp_valid), 64'd0);
            tick();
            chk("vec_lat_t2", 64'(resp_valid), 64'd1);
            chk("vec_id", 64'(resp_id), 64'(vt[v].id));
            chk("vec_sum", 64'(resp_sum), 64'(vt[v].sum));
            chk("vec_ovf", 64'(resp_overflow), 64'(vt[v].ovf));
            tick();
        end

        do_reset();
        grant_log.delete();
        resp_log.delete();
        resp_tick.delete();
        for (int i = 0; i < N; i++)
            set_req(i, 32'(i * 4096 + 1), 32'(i), logic'(i % 2));
        resp_ready = 1'b1;
        repeat (12) tick();
        req_valid = '0;
        repeat (4) tick();
        chk("order_grants", 64'(grant_log.size()), 64'd6);
        chk("order_resps", 64'(resp_log.size()), 64'd6);
        for (int k = 0; k < 6 && k < grant_log.size(); k++)
            chk("order_grant_id", 64'(grant_log[k]), 64'(exp_order[k]));
        for (int k = 0; k < 6 && k < resp_log.size(); k++) begin
            chk("order_resp_id", 64'(resp_log[k]), 64'(exp_order[k]));
            if (k > 0)
                chk("order_resp_spacing", 64'(resp_tick[k] - resp_tick[k-1]), 64'd2);
        end

        resp_ready = 1'b0;
        set_req(0, 32'h11, 32'h22, 1'b0);
        tick();
        chk("bp_grant0", 64'(last_ready), 64'd1);
        req_valid[0] = 1'b0;
        set_req(3, 32'h100, 32'h1, 1'b1);
        tick();
        chk("bp_exec_nogrant", 64'(last_ready), 64'd0);
        chk("bp_valid", 64'(resp_valid), 64'd1);
        chk("bp_sum", 64'(resp_sum), 64'h33);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_hold_ready", 64'(last_ready), 64'd0);
            chk("bp_hold_valid", 64'(resp_valid), 64'd1);
            chk("bp_hold_sum", 64'(resp_sum), 64'h33);
            chk("bp_hold_id", 64'(resp_id), 64'd0);
            chk("bp_hold_ovf", 64'(resp_overflow), 64'd0);
        end
        resp_ready = 1'b1;
        tick();
        chk("bp_grant3_same_cycle", 64'(last_ready), 64'b1000);
        req_valid[3] = 1'b0;
        chk("bp_valid_drop", 64'(resp_valid), 64'd0);
        tick();
        chk("bp_r3_valid", 64'(resp_valid), 64'd1);
        chk("bp_r3_id", 64'(resp_id), 64'd3);
        chk("bp_r3_sum", 64'(resp_sum), 64'hFF);
        tick();

        set_req(1, 32'hDEAD0000, 32'h0000BEEF, 1'b0);
        tick();
        chk("rx_grant1", 64'(last_ready), 64'b0010);
        rst = 1'b1;
        tick();
        chk("rx_resp_valid", 64'(resp_valid), 64'd0);
        chk("rx_resp_id", 64'(resp_id), 64'd0);
        chk("rx_resp_sum", 64'(resp_sum), 64'd0);
        chk("rx_resp_ovf", 64'(resp_overflow), 64'd0);
        rst = 1'b0;
        tick();
        chk("rx_regrant1", 64'(last_ready), 64'b0010);
        req_valid[1] = 1'b0;
        chk("rx_no_stale", 64'(resp_valid), 64'd0);
        tick();
        chk("rx_valid", 64'(resp_valid), 64'd1);
        chk("rx_id", 64'(resp_id), 64'd1);
        chk("rx_sum", 64'(resp_sum), 64'hDEADBEEF);
        tick();
        repeat (3) tick();
        chk("final_sb_empty", 64'(sb.size()), 64'd0);
        chk("final_idle_valid", 64'(resp_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cla_add_arbiter.md
Name: cla_add_arbiter

Overview:
- Time-shares one 32-bit carry-lookahead adder (a single b32_cla instance) between NUM_REQ requesters.
- Round-robin arbitration. Each request is an add or subtract.
- Results return on one shared response channel with backpressure.
- Sits between the execution-unit clients and the adder, and is the only block that drives the adder inputs.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of resp_id; must equal clog2(NUM_REQ)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester grant/accept, one-hot or zero
req_a  input  32*NUM_REQ  operand A, requester i at bits [32*i+31:32*i]
req_b  input  32*NUM_REQ  operand B, same packing
req_sub  input  NUM_REQ  1 = A-B, 0 = A+B
resp_valid  output  1  result valid
resp_ready  input  1  consumer accepts result
resp_id  output  ID_W  index of requester that owns result
resp_sum  output  32  A+B or A-B, modulo 2^32
resp_overflow  output  1  two's-complement signed overflow from adder

Behaviour:
- Reset: one clock, synchronous, active-high (clk, rst).
  - All state is cleared on rst=1 at the clock edge.
  - State=IDLE; rr_last=NUM_REQ-1, so requester 0 wins first.
  - resp_valid=0, resp_id=0, resp_sum=0, resp_overflow=0.
  - Operand registers are cleared.
  - req_ready=0 while rst=1.
- Handshake rules:
  - A request transfers on req_valid[i] & req_ready[i].
  - Requesters hold req_valid and operands stable until accepted.
  - The response transfers on resp_valid & resp_ready.
- req_ready is combinational from state, rr_last and req_valid:
  - at most one bit set;
  - only ever set for a bit whose req_valid is 1.
- All other outputs are registered.
- Arbitration: search req_valid starting at index rr_last+1, wrapping modulo NUM_REQ. The first set bit wins. On grant, rr_last takes the winner's index.
- Operand mapping to the adder:
  - X=opA_reg.
  - Y = sub_reg ? ~opB_reg : opB_reg.
  - C_in=sub_reg.
  - The adder is purely combinational from these registers.
- FSM states:
  - IDLE:
    - If any req_valid, assert req_ready[winner] this cycle.
    - Latch opA, opB, sub and id into registers, then go to EXEC.
    - Otherwise stay in IDLE.
  - EXEC (1 cycle):
    - Register adder Z into resp_sum, overflow into resp_overflow, id into resp_id.
    - Set resp_valid=1 and go to RESP.
    - No grant in this state.
  - RESP:
    - Hold resp_* stable while resp_ready=0; no grant.
    - When resp_ready=1 and any req_valid: resp_valid drops, the new winner is granted in the same cycle, and the FSM goes to EXEC.
    - When resp_ready=1 with no req_valid: clear resp_valid and go to IDLE.
- Timing:
  - Latency: grant at cycle t, then resp_valid=1 from cycle t+2.
  - Sustained throughput is one operation per 2 cycles when resp_ready=1 continuously.
- Boundary conditions:
  - A requester that drops req_valid before grant is simply not served. Deasserting while waiting is permitted but discouraged.
  - A requester that is granted and re-requests immediately waits behind all other pending requesters (fairness: max wait is NUM_REQ-1 grants).
  - With NUM_REQ bits all valid, grant order is strictly 0,1,…,NUM_REQ-1,0,…
  - Any in-flight operation is discarded on reset, and no stale response is ever emitted after reset.
  - Carry out of bit 31 is not reported; only overflow is.

Test Plan:
- Req0 add A=0x7FFFFFFF, B=0x00000001, resp_ready=1 -> req_ready=4'b0001 at t; at t+2 resp_valid=1, resp_id=0, resp_sum=0x80000000, resp_overflow=1.
- Req2 sub A=5, B=7 -> resp_id=2, resp_sum=0xFFFFFFFE, resp_overflow=0; Req1 sub A=0x80000000, B=1 -> resp_sum=0x7FFFFFFF, resp_overflow=1.
- All four req_valid held high, resp_ready=1, each re-requesting after accept -> grant order 0,1,2,3,0,1; resp_valid pulses every 2 cycles; resp_id sequence matches the grant order.
- Response backpressure: result pending, resp_ready=0 for 5 cycles while req3 valid -> resp_sum/resp_id/resp_overflow unchanged, req_ready=0 throughout; resp_ready=1 -> req3 granted in that same cycle, its result appears 2 cycles later.
- Reset asserted during EXEC (req1 granted previous cycle) -> next cycle resp_valid=0 and all resp_* =0; after release with only req1 valid, req1 is re-granted first (rr_last reset); no response for the discarded op.
- Idle/edge: no req_valid for 10 cycles -> req_ready=0, resp_valid=0; A=0xFFFFFFFF+B=1 add -> resp_sum=0x00000000, resp_overflow=0.
